decl_check_arbiter: RTL
=======================

// Module: decl_check_arbiter
// PURPOSE
//  Shares one declaration-checker core (int-declaration lexer FSM, enable-gated) among N_REQ char-stream requesters.
//  Round-robin grant; the grant stays locked until the requester's statement ends with ';', so statements never interleave.
//  One result per statement, tagged with the requester id. Per-requester saturating count of legal declarations.
//  Forces a statement to end (injected ';') when it exceeds MAX_LEN chars, so one requester cannot hog the checker.
// PARAMETERS
//  N_REQ    4   number of requesters
//  IDW      2   id width, equal to clog2(N_REQ)
//  MAX_LEN  64  max chars per statement, ';' excluded, before forced termination
//  CNT_W    8   width of each legal-declaration counter
// PORTS
//  clk        in   1          clock
//  reset      in   1          synchronous, active-high; also resets the checker core
//  req_valid  in   N_REQ      requester i has a char on req_char[8i+7:8i]
//  req_char   in   8*N_REQ    ASCII chars, packed
//  req_ready  out  N_REQ      char accepted this cycle when valid&ready; only the granted bit can be 1
//  chk_valid  out  1          checker consumes chk_char at this clk edge; checker holds state when 0
//  chk_char   out  8          char to checker
//  chk_out    in   1          checker "legal declaration just ended" flag
//  res_valid  out  1          one-cycle result pulse
//  res_id     out  IDW        requester id of the result
//  res_ok     out  1          statement was a legal declaration
//  res_abort  out  1          statement was force-terminated
//  cnt_sel    in   IDW        counter select
//  cnt_val    out  CNT_W      legal-declaration count of requester cnt_sel (combinational read)
//  busy       out  1          state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, grant=0, len=0, abort=0, all counters=0.
//   Outputs res_valid/res_id/res_ok/res_abort=0; req_ready=0; chk_valid=0; chk_char=0.
//   Reset has priority in every state, including mid-statement.
//  IDLE: no request -> stay. Otherwise pick the first i with req_valid[i], searching from rr_ptr upward and wrapping.
//   At the edge: grant<=i, rr_ptr<=(i+1) mod N_REQ, len<=0, go to LOCK. No char is transferred in the IDLE cycle.
//  LOCK: req_ready[grant]=1; all other ready bits 0.
//   chk_valid = req_valid[grant]; chk_char = req_char[grant] (combinational pass-through).
//   On transfer of ';' -> WAIT.
//   On transfer of any other char: len++. If len+1==MAX_LEN -> INJECT.
//   req_valid low -> chk_valid=0; checker state and len are held (stall), and the grant stays locked.
//  INJECT: req_ready=0; chk_valid=1, chk_char=";"; abort<=1; go to WAIT.
//  WAIT: checker has consumed ';' at the previous edge, so chk_out is valid in this cycle. At the edge:
//   res_valid<=1, res_id<=grant, res_ok<=chk_out & ~abort, res_abort<=abort, abort<=0, go to IDLE.
//   If res_ok: cnt[grant]++, saturating at 2^CNT_W-1.
//  res_* are registered; res_valid drops after one cycle. A new grant may be made in the cycle res_valid is high.
//  A lone ';' is reported with res_ok=0 (checker returns to start state).
//  Latency: statement of L chars, ';' included, with no stalls.
//   Grant cycle + L cycles + WAIT cycle; res_valid visible L+2 cycles after the grant cycle.
//  Fairness: a requester that keeps req_valid high is not granted again before every other waiting requester.
//  Requesters must hold req_char stable while valid and not ready.
// STRUCTURE
//  Shared package decl_pkg:
//   state enum {IDLE, LOCK, INJECT, WAIT} (2 bits)
//   char constants CH_SEMI=8'h3B, CH_SPACE=8'h20, CH_TAB=8'h09
//   checker enable-port convention
//  Sub-module rr_pick #(N_REQ): inputs req, ptr; outputs onehot grant, grant index, any.
//  Arbiter FSM, length counter and counter bank stay in this module.
// TESTING  (N_REQ=2, MAX_LEN=8 unless stated; checker core instantiated in the bench)
//  1 req0 streams "int a;" -> chk_char sequence equals the input. res_valid pulse: res_id=0, res_ok=1, res_abort=0. cnt_val[0]=1.
//  2 req0 "int x;" and req1 "intx;" both valid at the same cycle -> req0 served first, req_ready[1]=0 throughout.
//    Then req1 is served: res_ok=1 for id 0, then res_ok=0 for id 1. cnt 1/0.
//  3 req0 "int b,c;" with req_valid low 3 cycles after ',' -> chk_valid=0 those 3 cycles. Result res_ok=1; latency +3.
//  4 req0 sends "int abcdefg" without ';' -> after the 8th char req_ready drops and chk_char=';' for one cycle.
//    Result res_abort=1, res_ok=0. Next grant goes to req1 if it is requesting.
//  5 CNT_W=8: 260 legal statements from req1 -> cnt_val[1]=255, never wraps.
//  6 reset asserted in LOCK mid-statement -> next cycle busy=0, req_ready=0, counters 0.
//    Requests then arriving from both requesters grant req0 first.

Source files
------------

// File: rtl/decl_pkg.sv
// decl_pkg: shared state encoding, character constants and checker enable level
// for the declaration-check arbiter.
package decl_pkg;
  typedef enum logic [1:0] {IDLE, LOCK, INJECT, WAIT} state_t;
  localparam logic [7:0] CH_SEMI  = 8'h3B;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_TAB   = 8'h09;
  // The checker core advances only on edges where its enable equals CHK_EN.
  localparam logic CHK_EN = 1'b1;
endpackage

// File: rtl/decl_check_arbiter_rr_pick.sv
// rr_pick: round-robin selector, first requester at or above ptr, wrapping.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDW-1:0]   idx,
  output logic             any
);
  always_comb begin
    idx = '0;
    any = 1'b0;
    // Scan from farthest to nearest so the nearest match wins.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N_REQ]) begin
        idx = IDW'((int'(ptr) + k) % N_REQ);
        any = 1'b1;
      end
    end
    gnt = any ? N_REQ'(1) << idx : '0;
  end
endmodule

// File: rtl/decl_check_arbiter.sv
// decl_check_arbiter: shares one declaration-checker core among N_REQ char streams,
// locking the grant for a whole statement and force-ending overlong ones.
module decl_check_arbiter
  import decl_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int IDW     = 2,
  parameter int MAX_LEN = 64,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_char,
  output logic [N_REQ-1:0]   req_ready,
  output logic               chk_valid,
  output logic [7:0]         chk_char,
  input  logic               chk_out,
  output logic               res_valid,
  output logic [IDW-1:0]     res_id,
  output logic               res_ok,
  output logic               res_abort,
  input  logic [IDW-1:0]     cnt_sel,
  output logic [CNT_W-1:0]   cnt_val,
  output logic               busy
);
  localparam int LW = $clog2(MAX_LEN + 1);
  state_t state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d, grant_q, grant_d, res_id_q, res_id_d, pick_idx;
  logic [N_REQ-1:0] grant_oh_q, grant_oh_d, pick_gnt;
  logic [LW-1:0] len_q, len_d;
  logic abort_q, abort_d, res_valid_q, res_valid_d, res_ok_q, res_ok_d, res_abort_q, res_abort_d;
  logic pick_any, xfer, ok;
  logic [7:0] cur_char;
  logic [CNT_W-1:0] cnt_q [N_REQ];
  logic [CNT_W-1:0] cnt_d [N_REQ];

  rr_pick #(.N_REQ(N_REQ), .IDW(IDW)) u_pick (
    .req(req_valid), .ptr(rr_ptr_q), .gnt(pick_gnt), .idx(pick_idx), .any(pick_any)
  );

  always_comb begin
    cur_char = req_char[8*int'(grant_q) +: 8];
    xfer = state_q == LOCK && req_valid[grant_q];
    ok = chk_out & ~abort_q;
    req_ready = state_q == LOCK ? grant_oh_q : '0;
    chk_valid = (state_q == INJECT || xfer) ? CHK_EN : ~CHK_EN;
    chk_char = state_q == INJECT ? CH_SEMI : state_q == LOCK ? cur_char : 8'h00;
    state_d = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d = grant_q;
    grant_oh_d = grant_oh_q;
    len_d = len_q;
    abort_d = abort_q;
    res_valid_d = 1'b0;
    res_id_d = res_id_q;
    res_ok_d = res_ok_q;
    res_abort_d = res_abort_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (pick_any) begin
        grant_d = pick_idx;
        grant_oh_d = pick_gnt;
        rr_ptr_d = IDW'((int'(pick_idx) + 1) % N_REQ);
        len_d = '0;
        state_d = LOCK;
      end
      LOCK: if (xfer) begin
        len_d = cur_char == CH_SEMI ? len_q : len_q + 1'b1;
        state_d = cur_char == CH_SEMI ? WAIT : (int'(len_q) + 1 == MAX_LEN) ? INJECT : LOCK;
      end
      INJECT: begin
        abort_d = 1'b1;
        state_d = WAIT;
      end
      default: begin
        res_valid_d = 1'b1;
        res_id_d = grant_q;
        res_ok_d = ok;
        res_abort_d = abort_q;
        abort_d = 1'b0;
        state_d = IDLE;
        if (ok && cnt_q[grant_q] != '1) cnt_d[grant_q] = cnt_q[grant_q] + 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rr_ptr_q <= '0;
      grant_q <= '0;
      grant_oh_q <= '0;
      len_q <= '0;
      abort_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_id_q <= '0;
      res_ok_q <= 1'b0;
      res_abort_q <= 1'b0;
      cnt_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q <= grant_d;
      grant_oh_q <= grant_oh_d;
      len_q <= len_d;
      abort_q <= abort_d;
      res_valid_q <= res_valid_d;
      res_id_q <= res_id_d;
      res_ok_q <= res_ok_d;
      res_abort_q <= res_abort_d;
      cnt_q <= cnt_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_id = res_id_q;
  assign res_ok = res_ok_q;
  assign res_abort = res_abort_q;
  assign cnt_val = cnt_q[cnt_sel];
  assign busy = state_q != IDLE;
endmodule
